// File: rtl/dct_pkg.sv
// Shared constants and datapath types for the 8-point DCT/IDCT blocks.
// ACC_WIDTH holds any 16-bit-input butterfly result, so nothing can wrap before the final clip.
package dct_pkg;

    localparam int OUT_WIDTH = 16;
    localparam int ACC_WIDTH = 2*OUT_WIDTH + 1;

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    localparam acc_t C64 = acc_t'(64);
    localparam acc_t C83 = acc_t'(83);
    localparam acc_t C36 = acc_t'(36);
    localparam acc_t C89 = acc_t'(89);
    localparam acc_t C75 = acc_t'(75);
    localparam acc_t C50 = acc_t'(50);
    localparam acc_t C18 = acc_t'(18);

    typedef struct packed {
        acc_t o0;
        acc_t o1;
        acc_t o2;
        acc_t o3;
    } idct_odd_struct;

    typedef struct packed {
        acc_t ee0;
        acc_t ee1;
        acc_t eo0;
        acc_t eo1;
    } idct_even_struct;

endpackage

// File: rtl/idct8_odd_mac.sv
// Odd half of the 8-point inverse butterfly: 4x4 constant multiply of c1, c3, c5 and c7.
module idct8_odd_mac
    import dct_pkg::*;
#(
    parameter int IN_WIDTH = 16
) (
    input  logic signed [IN_WIDTH-1:0] c1_i,
    input  logic signed [IN_WIDTH-1:0] c3_i,
    input  logic signed [IN_WIDTH-1:0] c5_i,
    input  logic signed [IN_WIDTH-1:0] c7_i,
    output idct_odd_struct             odd_o
);

    acc_t x1, x3, x5, x7;

    always_comb begin
        x1 = acc_t'(c1_i);
        x3 = acc_t'(c3_i);
        x5 = acc_t'(c5_i);
        x7 = acc_t'(c7_i);
        odd_o.o0 = C89*x1 + C75*x3 + C50*x5 + C18*x7;
        odd_o.o1 = C75*x1 - C18*x3 - C89*x5 - C50*x7;
        odd_o.o2 = C50*x1 - C89*x3 + C18*x5 + C75*x7;
        odd_o.o3 = C18*x1 - C50*x3 + C75*x5 - C89*x7;
    end

endmodule

// File: rtl/idct8_1d_pipe.sv
// 1-D 8-point inverse integer DCT, three register stages behind a single global stall enable.
// S1: constant products, S2: butterfly recombination, S3: round, shift and saturate.
module idct8_1d_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = dct_pkg::OUT_WIDTH,
    parameter int SHIFT     = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*IN_WIDTH-1:0]  in_coef,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*OUT_WIDTH-1:0] out_samp
);
    import dct_pkg::*;

    localparam acc_t RND  = acc_t'(1) <<< (SHIFT-1);
    localparam acc_t MAXV = acc_t'(2**(OUT_WIDTH-1) - 1);
    localparam acc_t MINV = -MAXV - acc_t'(1);

    logic                    adv;
    logic [2:0]              vld_q;
    logic signed [IN_WIDTH-1:0] c [8];
    idct_odd_struct          odd_d, odd_q;
    idct_even_struct         even_d, even_q;
    acc_t                    e [4];
    acc_t                    o [4];
    acc_t                    y_d [8];
    acc_t                    y_q [8];
    acc_t                    r [8];
    logic [8*OUT_WIDTH-1:0]  samp_d, samp_q;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv       = !vld_q[2] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[2];
    assign out_samp  = samp_q;

    always_comb begin
        for (int k = 0; k < 8; k++) c[k] = in_coef[k*IN_WIDTH +: IN_WIDTH];
    end

    idct8_odd_mac #(.IN_WIDTH(IN_WIDTH)) u_odd (
        .c1_i  (c[1]),
        .c3_i  (c[3]),
        .c5_i  (c[5]),
        .c7_i  (c[7]),
        .odd_o (odd_d)
    );

    always_comb begin
        even_d.ee0 = C64 * (acc_t'(c[0]) + acc_t'(c[4]));
        even_d.ee1 = C64 * (acc_t'(c[0]) - acc_t'(c[4]));
        even_d.eo0 = C83*acc_t'(c[2]) + C36*acc_t'(c[6]);
        even_d.eo1 = C36*acc_t'(c[2]) - C83*acc_t'(c[6]);
    end

    always_comb begin
        e[0] = even_q.ee0 + even_q.eo0;
        e[1] = even_q.ee1 + even_q.eo1;
        e[2] = even_q.ee1 - even_q.eo1;
        e[3] = even_q.ee0 - even_q.eo0;
        o[0] = odd_q.o0;
        o[1] = odd_q.o1;
        o[2] = odd_q.o2;
        o[3] = odd_q.o3;
        for (int k = 0; k < 4; k++) begin
            y_d[k]   = e[k] + o[k];
            y_d[7-k] = e[k] - o[k];
        end
    end

    // Arithmetic shift floors toward -inf, so adding half an LSB first gives round-half-up.
    always_comb begin
        samp_d = '0;
        for (int n = 0; n < 8; n++) begin
            r[n] = (y_q[n] + RND) >>> SHIFT;
            if (r[n] > MAXV)      r[n] = MAXV;
            else if (r[n] < MINV) r[n] = MINV;
            samp_d[n*OUT_WIDTH +: OUT_WIDTH] = r[n][OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            odd_q  <= '0;
            even_q <= '0;
            samp_q <= '0;
            for (int n = 0; n < 8; n++) y_q[n] <= '0;
        end else if (adv) begin
            vld_q  <= {vld_q[1:0], in_valid};
            odd_q  <= odd_d;
            even_q <= even_d;
            samp_q <= samp_d;
            for (int n = 0; n < 8; n++) y_q[n] <= y_d[n];
        end
    end

endmodule

// File: tb/tb_idct8_1d_pipe.sv
// Scoreboard bench for idct8_1d_pipe: SHIFT=7 and SHIFT=12 instances share stimulus,
// expectations come from a direct 8x8 matrix-product reference model.
module tb_idct8_1d_pipe;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] in_coef = '0;
    logic         in_ready7, in_ready12, out_valid7, out_valid12;
    logic [127:0] out7, out12;

    int           n_chk = 0;
    int           n_fail = 0;
    int           rdy_mode = 0;   // 0: held by main, 1: 50% ready, 2: 75% ready
    logic [127:0] q7[$];
    logic [127:0] q12[$];
    logic         stall = 1'b0;
    logic [127:0] prev7, prev12;

    // Row k = basis function of coefficient k, column n = output sample n.
    int T [8][8] = '{
        '{64,  64,  64,  64,  64,  64,  64,  64},
        '{89,  75,  50,  18, -18, -50, -75, -89},
        '{83,  36, -36, -83, -83, -36,  36,  83},
        '{75, -18, -89, -50,  50,  89,  18, -75},
        '{64, -64, -64,  64,  64, -64, -64,  64},
        '{50, -89,  18,  75, -75, -18,  89, -50},
        '{36, -83,  83, -36, -36,  83, -83,  36},
        '{18, -50,  75, -89,  89, -75,  50, -18}};

    idct8_1d_pipe #(.SHIFT(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready7), .in_coef(in_coef),
        .out_valid(out_valid7), .out_ready(out_ready), .out_samp(out7));

    idct8_1d_pipe #(.SHIFT(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready12), .in_coef(in_coef),
        .out_valid(out_valid12), .out_ready(out_ready), .out_samp(out12));

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1)      out_ready = ($urandom_range(0, 1) == 1);
        else if (rdy_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [127:0] model(input logic [127:0] v, input int sh);
        logic [127:0] res = '0;
        longint y, rr;
        for (int n = 0; n < 8; n++) begin
            y = 0;
            for (int k = 0; k < 8; k++) y += longint'($signed(v[k*16 +: 16])) * longint'(T[k][n]);
            rr = (y + (longint'(1) <<< (sh-1))) >>> sh;
            if (rr > 32767) rr = 32767;
            if (rr < -32768) rr = -32768;
            res[n*16 +: 16] = rr[15:0];
        end
        return res;
    endfunction

    function automatic logic [127:0] rnd_vec();
        logic [127:0] v;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 7))
                0:       v[k*16 +: 16] = 16'h8000;
                1:       v[k*16 +: 16] = 16'h7fff;
                2:       v[k*16 +: 16] = 16'h0000;
                default: v[k*16 +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: handshake rule, stall stability, and in-order scoreboard pops.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            chk("in_ready7", 128'(in_ready7), 128'(!(out_valid7 && !out_ready)));
            chk("in_ready12", 128'(in_ready12), 128'(!(out_valid12 && !out_ready)));
            if (stall) begin
                chk("stall_valid", 128'(out_valid7 && out_valid12), 128'(1));
                chk("stall_hold7", out7, prev7);
                chk("stall_hold12", out12, prev12);
            end
            if (out_valid7 || out_valid12) begin
                if (q7.size() == 0 || q12.size() == 0) begin
                    chk("unexpected_output", 128'(out_valid7 || out_valid12), 128'(0));
                end else if (out_ready) begin
                    chk("samp_shift7", out7, q7.pop_front());
                    chk("samp_shift12", out12, q12.pop_front());
                end
            end
            stall  = out_valid7 && !out_ready;
            prev7  = out7;
            prev12 = out12;
        end
    end

    // Caller must be just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [127:0] v);
        bit ok = 1'b0;
        in_coef  = v;
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (in_ready7) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 128'(0), 128'(1));
        q7.push_back(model(v, 7));
        q12.push_back(model(v, 12));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Expects an empty pipe and out_ready held high; checks the exact 3-cycle latency.
    task automatic send_lat(input logic [127:0] v, output logic [127:0] got);
        @(posedge clk);
        #1;
        in_coef  = v;
        in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", 128'(in_ready7), 128'(1));
        q7.push_back(model(v, 7));
        q12.push_back(model(v, 12));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_c1", 128'(out_valid7), 128'(0));
        @(negedge clk);
        chk("lat_c2", 128'(out_valid7), 128'(0));
        @(negedge clk);
        chk("lat_c3", 128'(out_valid7), 128'(1));
        got = out7;
    endtask

    task automatic drain();
        rdy_mode  = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && q7.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 128'(q7.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lanes(input string name, input logic [127:0] got, input int exp [8]);
        logic [127:0] e = '0;
        for (int n = 0; n < 8; n++) e[n*16 +: 16] = 16'(exp[n]);
        chk(name, got, e);
    endtask

    initial begin
        logic [127:0] v, got;

        #1;
        chk("rst_valid7", 128'(out_valid7), 128'(0));
        chk("rst_samp7", out7, 128'(0));
        chk("rst_valid12", 128'(out_valid12), 128'(0));
        chk("rst_samp12", out12, 128'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready7), 128'(1));

        v = '0; v[15:0] = 16'd64;
        send_lat(v, got);
        chk_lanes("dc", got, '{32, 32, 32, 32, 32, 32, 32, 32});
        drain();

        v = '0; v[31:16] = 16'd64;
        send_lat(v, got);
        chk_lanes("odd_basis", got, '{45, 38, 25, 9, -9, -25, -37, -44});
        drain();

        v = '0; v[15:0] = 16'h7fff; v[47:32] = 16'h7fff; v[79:64] = 16'h7fff;
        send_lat(v, got);
        chk_lanes("clip", got, '{32767, 9216, -9216, 11520, 11520, -9216, 9216, 32767});
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 6; i++) send(rnd_vec());
        drain();

        // Fill the pipe with the sink stalled, then reset with three vectors in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rnd_vec());
        chk("pre_rst_valid", 128'(out_valid7), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 128'(out_valid7 || out_valid12), 128'(0));
        chk("midrst_samp7", out7, 128'(0));
        chk("midrst_samp12", out12, 128'(0));
        q7.delete();
        q12.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        v = rnd_vec();
        send_lat(v, got);
        chk("post_rst_vec", got, model(v, 7));
        drain();

        rdy_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            send(rnd_vec());
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
